// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} pairs between fetch and decode.
// f_ready/d_valid/count are decoded from registers only, so no input reaches an output.
module fetch_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_valid,
  input  logic [31:0]   f_pc,
  input  logic [31:0]   f_instr,
  output logic          f_ready,
  output logic          d_valid,
  output logic [31:0]   d_pc,
  output logic [31:0]   d_instr,
  input  logic          d_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign f_ready = (r_count != (AW+1)'(DEPTH));
  assign d_valid = (r_count != '0);
  assign count   = r_count;
  assign d_pc    = r_mem[r_rd_ptr][63:32];
  assign d_instr = r_mem[r_rd_ptr][31:0];

  assign w_push = f_valid & f_ready & ~flush;
  assign w_pop  = d_valid & d_ready & ~flush;

  // Entries are only cleared by reset; flush just rewinds the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {f_pc, f_instr};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
